// File: rtl/vwin5_linebuf_sint18_if.sv
// Handshake/window bundle for the 5x1 vertical window producer (sint18 pixels).
interface vwin5_linebuf_sint18_if #(
  parameter int unsigned DATA_W = 18
);
  logic signed [DATA_W-1:0] data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [4:0][DATA_W-1:0]   window_o;
  logic [15:0]              col_o;
  logic [15:0]              row_o;
  logic                     valid_o;

  modport slave (
    input  data_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o
  );

  modport master (
    output data_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/vwin5_linebuf_sint18.sv
// 4-line buffer producing one 5x1 column window per pixel, with a 2-row flush per frame.
// Optional macro VWIN5_MIRROR_BORDER_EN selects reflect borders instead of edge replicate.
module vwin5_linebuf_sint18 #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned DATA_W     = 18
) (
  input logic                   clk_i,
  input logic                   rst_i,
  vwin5_linebuf_sint18_if.slave bus
);

  localparam int unsigned AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [15:0]            in_col_q, in_col_d;
  logic [15:0]            in_row_q, in_row_d;
  logic [15:0]            fl_col_q, fl_col_d;
  logic [15:0]            fl_row_q, fl_row_d;
  logic                   valid_q, valid_d;
  logic [4:0][DATA_W-1:0] win_q, win_d;
  logic [15:0]            col_q, row_q;
  logic [15:0]            cen_row, cen_col;
  logic                   accept, flushing;
  int                     idx;

  logic [DATA_W-1:0] mem_q [4][IMG_WIDTH];

  function automatic int src_row(input int t);
`ifdef VWIN5_MIRROR_BORDER_EN
    if (t < 0) return -t;
    if (t > int'(IMG_HEIGHT) - 1) return 2 * (int'(IMG_HEIGHT) - 1) - t;
    return t;
`else
    if (t < 0) return 0;
    if (t > int'(IMG_HEIGHT) - 1) return int'(IMG_HEIGHT) - 1;
    return t;
`endif
  endfunction

  assign flushing    = (state_q == FLUSH);
  assign bus.ready_o = !flushing;
  assign accept      = bus.valid_i && !flushing;

  assign bus.valid_o  = valid_q;
  assign bus.window_o = win_q;
  assign bus.col_o    = col_q;
  assign bus.row_o    = row_q;

  // Centre lags input by two rows while streaming; flush walks its own counters.
  assign cen_row = flushing ? fl_row_q : in_row_q - 16'd2;
  assign cen_col = flushing ? fl_col_q : in_col_q;
  assign valid_d = flushing || (accept && state_q == STREAM);

  // RAM reads are combinational and see pre-write data, so the slot being
  // overwritten by row r still yields row r-4 in the same cycle.
  always_comb begin
    win_d = '0;
    idx   = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = src_row(int'(cen_row) + int'(k) - 2);
      if (state_q == STREAM && idx == int'(in_row_q))
        win_d[k] = bus.data_i;
      else
        win_d[k] = mem_q[idx[1:0]][cen_col[AW-1:0]];
    end
  end

  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    fl_col_d = fl_col_q;
    fl_row_d = fl_row_q;
    if (flushing) begin
      if (fl_col_q == LAST_COL) begin
        fl_col_d = '0;
        if (fl_row_q == LAST_ROW) begin
          state_d  = FILL;
          in_row_d = '0;
          in_col_d = '0;
        end else begin
          fl_row_d = fl_row_q + 16'd1;
        end
      end else begin
        fl_col_d = fl_col_q + 16'd1;
      end
    end else if (accept) begin
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        in_row_d = in_row_q + 16'd1;
        if (state_q == FILL && in_row_q == 16'd1)
          state_d = STREAM;
        if (state_q == STREAM && in_row_q == LAST_ROW) begin
          state_d  = FLUSH;
          fl_row_d = LAST_ROW - 16'd1;
          fl_col_d = '0;
        end
      end else begin
        in_col_d = in_col_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept)
      mem_q[in_row_q[1:0]][in_col_q[AW-1:0]] <= bus.data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= FILL;
      in_col_q <= '0;
      in_row_q <= '0;
      fl_col_q <= '0;
      fl_row_q <= '0;
      valid_q  <= 1'b0;
      win_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      fl_col_q <= fl_col_d;
      fl_row_q <= fl_row_d;
      valid_q  <= valid_d;
      if (valid_d) begin
        win_q <= win_d;
        col_q <= cen_col;
        row_q <= cen_row;
      end
    end
  end

endmodule

// File: doc/vwin5_linebuf_sint18.md
Name: vwin5_linebuf_sint18

Overview:
- Producer side of the 5x1 vertical window interface; feeds the vertical binomial filter stages in the dfdd pipeline.
- Accepts a raster-order sint18 pixel stream.
- Holds 4 previous lines in line buffers and emits one 5x1 column window per pixel, centred on row c, with coordinates and valid.
- Handles top and bottom borders, including a flush phase that emits the last two rows of each frame.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=2).
- IMG_HEIGHT, 480, lines per frame (>=4).
- DATA_W, 18, signed pixel width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-low.
- data_i  in  DATA_W  signed input pixel.
- valid_i  in  1  data_i valid; a pixel is accepted when valid_i && ready_o.
- ready_o  out  1  block can accept a pixel.
- window_o  out  [5][1] x DATA_W  column window; [0]=row c-2 (top) ... [4]=row c+2 (bottom).
- col_o  out  16  centre column.
- row_o  out  16  centre row c.
- valid_o  out  1  window_o/col_o/row_o valid.

Behaviour:
- Reset (rst_i=0 at posedge):
  - valid_o=0; window_o, col_o, row_o = 0; ready_o=1.
  - In-column and in-row counters = 0; state=FILL.
  - Line-buffer contents are don't-care.
- Internal counters:
  - in_col advances on each accepted pixel and wraps at IMG_WIDTH-1.
  - in_row increments on each wrap.
  - No frame markers; frames are delimited by counters only.
- Storage:
  - 4 line RAMs, IMG_WIDTH x DATA_W.
  - Row r is stored in slot r mod 4 at address in_col.
  - Reads are read-first: a same-address write in the same cycle returns the old data, which holds row r-4.
- States:
  - FILL: rows 0..1. Store only; valid_o=0. Go to STREAM after the last pixel of row 1 is accepted.
  - STREAM: rows 2..IMG_HEIGHT-1. Each accepted pixel (r, x) produces a window centred on (r-2, x). Rows r-4..r-1 come from RAM; row r is the live data_i. After the last pixel of row IMG_HEIGHT-1 is accepted, go to FLUSH.
  - FLUSH: ready_o=0. Emit 2*IMG_WIDTH windows, one per cycle, for centres IMG_HEIGHT-2 then IMG_HEIGHT-1, cols 0..W-1. All rows are read from RAM. After the last flush window, return to FILL with in_row=0, in_col=0, and ready_o=1 in the same cycle.
- Timing:
  - Latency is 1 cycle: outputs are registered and update the cycle after acceptance.
  - valid_o=0 in any cycle with no acceptance and not flushing.
  - Gaps in valid_i are allowed anywhere; output content must not depend on gaps.
- Border replicate (default):
  - Source row index = clamp(c+k, 0, IMG_HEIGHT-1) for k=-2..2, then mapped to slot (index mod 4). The clamped index IMG_HEIGHT-1 during STREAM maps to the live pixel when equal to r.
- Bit exactness: data passes through unmodified. No arithmetic other than index math.
- Mid-operation reset: the full reset state applies in the next cycle, regardless of state, including during FLUSH.
- valid_i asserted during FLUSH is ignored, and no data is accepted.

Optional Feature:
- Macro: VWIN5_MIRROR_BORDER_EN.
- Defined: border rows are reflected without repeating the edge row. Row -1 maps to 1, -2 to 2, IMG_HEIGHT to IMG_HEIGHT-2, and IMG_HEIGHT+1 to IMG_HEIGHT-3.
- Undefined: edge replicate as above.
- Latency, handshake and FSM are identical in both modes.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles -> valid_o=0, ready_o=1, window_o all 0.
- First window:
  - Setup: W=4, H=6, pixel = row*16+col, valid_i continuous.
  - Response: first valid_o is 1 cycle after (2,0) is accepted, with row_o=0, col_o=0, window {0,0,0,16,32}. There is no valid_o during rows 0-1.
- Interior window: same frame, centre (3,1) -> window {17,33,49,65,81}.
- Flush:
  - After (5,3) is accepted, ready_o=0 for exactly 8 cycles.
  - The 8 windows are centred on rows 4,5; centre (5,2) = {50,66,82,82,82}.
  - ready_o=1 afterward; the next frame restarts with FILL.
- Gapped input: random valid_i gaps of 0-3 cycles give a window sequence identical to the continuous case. Two back-to-back frames also give identical output.
- Reset mid-frame: rst_i=0 while accepting row 3 -> valid_o=0 the next cycle. The next frame starts from row 0 and the first window again equals {0,0,0,16,32}.
- Mirror mode (VWIN5_MIRROR_BORDER_EN):
  - Centre (0,0) -> {32,16,0,16,32}.
  - Centre (5,2) -> {50,66,82,66,50}.
